// File: rtl/param_lifo_stack.sv
// param_lifo_stack: parametrised LIFO with push-source mux, registered pop
// output, occupancy count and sticky errors; optional LIFO_HIGH_WATER_EN.
module param_lifo_stack #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              mux_sel,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
`ifdef LIFO_HIGH_WATER_EN
  ,
  output logic [ADDR_W:0]   high_water
`endif
);

  localparam logic [ADDR_W:0] FULL_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C  = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [DATA_W-1:0] push_data;
  logic [ADDR_W:0]   top_sum;
  logic [ADDR_W-1:0] top_idx;
  logic [ADDR_W-1:0] free_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic              we;
  logic              is_full;
  logic              is_empty;

  assign push_data = mux_sel ? pc_in : data_in;
  assign is_full   = (count_q == FULL_C);
  assign is_empty  = (count_q == '0);
  assign top_sum   = count_q - ONE_C;
  assign top_idx   = top_sum[ADDR_W-1:0];
  assign free_idx  = count_q[ADDR_W-1:0];

  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    wr_idx  = free_idx;
    unique case (1'b1)
      // replace top: read old top, overwrite in place
      (push && pop && !is_empty): begin
        dout_d  = mem_q[top_idx];
        valid_d = 1'b1;
        we      = 1'b1;
        wr_idx  = top_idx;
      end
      // pop on empty is ignored, push still lands
      (push && pop && is_empty): begin
        we      = 1'b1;
        count_d = count_q + ONE_C;
        unf_d   = 1'b1;
      end
      (push && !pop && !is_full): begin
        we      = 1'b1;
        count_d = count_q + ONE_C;
      end
      (push && !pop && is_full): begin
        ovf_d = 1'b1;
      end
      (pop && !push && !is_empty): begin
        dout_d  = mem_q[top_idx];
        valid_d = 1'b1;
        count_d = count_q - ONE_C;
      end
      (pop && !push && is_empty): begin
        unf_d = 1'b1;
      end
      default: begin
      end
    endcase
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // storage is not cleared by reset; a write is suppressed while rst is high
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem_q[wr_idx] <= push_data;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign count      = count_q;
  assign full       = is_full;
  assign empty      = is_empty;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

`ifdef LIFO_HIGH_WATER_EN
  logic [ADDR_W:0] hw_q, hw_d;

  assign hw_d = (count_d > hw_q) ? count_d : hw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw_q <= '0;
    end else begin
      hw_q <= hw_d;
    end
  end

  assign high_water = hw_q;
`endif

endmodule
